// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param
//   Parametrised register file for the multicycle MIPS datapath. It has two
//   registered read ports, one write port with a write-to-read bypass, and a
//   hardware clear sequencer. The sequencer zeroes every entry after reset, so
//   no memory-image preload is needed.
//
// Parameters
//   DATA_W   : register width in bits
//   ADDR_W   : address width, DEPTH = 2**ADDR_W entries
//   ZERO_REG : 1 = entry 0 reads as 0 and ignores writes, 0 = ordinary entry
//
// Ports
//   clk      : clock, all state updates on posedge
//   reset    : synchronous, active-high, (re)starts the clear sequence
//   ra1/ra2  : read addresses (rs / rt)
//   re       : read enable, rd1/rd2 hold when low
//   rd1/rd2  : registered read data, 1-cycle latency
//   we/wa/wd : write enable, address, data
//   busy     : high while the clear sequence runs
//
// Optional feature (macro REGFILE_DEBUG_PORT_EN)
//   dbg_a/dbg_d : always-enabled registered debug read port with no bypass.
//                 It shows the pre-write contents on a same-edge write.
// -----------------------------------------------------------------------------
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic              re,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
`ifdef REGFILE_DEBUG_PORT_EN
    input  logic [ADDR_W-1:0] dbg_a,
    output logic [DATA_W-1:0] dbg_d,
`endif
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] mem [DEPTH];

    // A single write port into the array, shared by the clear sequencer and
    // the normal write path.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Operand read value. A same-edge write is forwarded so the operand
    // registers never see stale data.
    function automatic logic [DATA_W-1:0] read_sel(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic              w_en,
        input logic [ADDR_W-1:0] w_addr,
        input logic [DATA_W-1:0] w_data
    );
        if (is_zero_reg(a))
            return '0;
        else if (w_en && (w_addr == a))
            return w_data;
        else
            return stored;
    endfunction

`ifdef REGFILE_DEBUG_PORT_EN
    logic [DATA_W-1:0] dbg_d_q, dbg_d_d;
`endif

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        rd1_d     = rd1_q;
        rd2_d     = rd2_q;
        busy_d    = busy_q;
        mem_we    = 1'b0;
        mem_wa    = wa;
        mem_wd    = wd;
`ifdef REGFILE_DEBUG_PORT_EN
        dbg_d_d   = '0;
`endif

        if (reset) begin
            state_d   = CLEAR;
            clr_ptr_d = '0;
            rd1_d     = '0;
            rd2_d     = '0;
            busy_d    = 1'b1;
        end else if (state_q == CLEAR) begin
            // One entry is zeroed per cycle. External writes and reads are
            // locked out, so uninitialised storage can never reach rd1/rd2.
            mem_we    = 1'b1;
            mem_wa    = clr_ptr_q;
            mem_wd    = '0;
            clr_ptr_d = clr_ptr_q + 1'b1;
            rd1_d     = '0;
            rd2_d     = '0;
            if (clr_ptr_q == {ADDR_W{1'b1}}) begin
                state_d = READY;
                busy_d  = 1'b0;
            end
        end else begin
            mem_we = we && !is_zero_reg(wa);
            if (re) begin
                rd1_d = read_sel(ra1, mem[ra1], we, wa, wd);
                rd2_d = read_sel(ra2, mem[ra2], we, wa, wd);
            end
`ifdef REGFILE_DEBUG_PORT_EN
            dbg_d_d = is_zero_reg(dbg_a) ? '0 : mem[dbg_a];
`endif
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        clr_ptr_q <= clr_ptr_d;
        rd1_q     <= rd1_d;
        rd2_q     <= rd2_d;
        busy_q    <= busy_d;
`ifdef REGFILE_DEBUG_PORT_EN
        dbg_d_q   <= dbg_d_d;
`endif
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

    assign rd1  = rd1_q;
    assign rd2  = rd2_q;
    assign busy = busy_q;
`ifdef REGFILE_DEBUG_PORT_EN
    assign dbg_d = dbg_d_q;
`endif

endmodule

// File: tb/tb_regfile_param.sv
// -----------------------------------------------------------------------------
// tb_regfile_param
//   Self-checking bench for regfile_param (DATA_W=32, ADDR_W=5, ZERO_REG=1).
//   Expected read data is pushed to a queue when a READY-phase cycle is
//   driven. It is popped and compared once the DUT register updates. The
//   debug port is checked when REGFILE_DEBUG_PORT_EN is defined.
// -----------------------------------------------------------------------------
module tb_regfile_param;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int ZR = 1;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          re    = 1'b0;
    logic          we    = 1'b0;
    logic [AW-1:0] ra1   = '0;
    logic [AW-1:0] ra2   = '0;
    logic [AW-1:0] wa    = '0;
    logic [DW-1:0] wd    = '0;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          busy;
`ifdef REGFILE_DEBUG_PORT_EN
    logic [AW-1:0] dbg_a = '0;
    logic [DW-1:0] dbg_d;
`endif

    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR)) dut (
        .clk   (clk),
        .reset (reset),
        .ra1   (ra1),
        .ra2   (ra2),
        .re    (re),
        .rd1   (rd1),
        .rd2   (rd2),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
`ifdef REGFILE_DEBUG_PORT_EN
        .dbg_a (dbg_a),
        .dbg_d (dbg_d),
`endif
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int            n_chk  = 0;
    int            n_fail = 0;
    logic [DW-1:0] mdl [32];
    logic [DW-1:0] last1 = '0;
    logic [DW-1:0] last2 = '0;
    logic [DW-1:0] q1 [$];
    logic [DW-1:0] q2 [$];
`ifdef REGFILE_DEBUG_PORT_EN
    logic [DW-1:0] qd [$];
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        if (ZR != 0 && a == '0) return '0;
        if (we && wa == a)      return wd;
        return mdl[a];
    endfunction

    // One READY-phase cycle: drive, push expectations, clock, pop and compare.
    task automatic rw(input string tag, input int i_re, input int a1, input int a2,
                      input int i_we, input int w_a, input logic [DW-1:0] w_d);
        logic [DW-1:0] e1, e2;
        re  = (i_re != 0);
        ra1 = AW'(a1);
        ra2 = AW'(a2);
        we  = (i_we != 0);
        wa  = AW'(w_a);
        wd  = w_d;
        q1.push_back(re ? ref_rd(ra1) : last1);
        q2.push_back(re ? ref_rd(ra2) : last2);
`ifdef REGFILE_DEBUG_PORT_EN
        dbg_a = ra1;
        qd.push_back((ZR != 0 && dbg_a == '0) ? '0 : mdl[dbg_a]);
`endif
        if (we && !(ZR != 0 && wa == '0)) mdl[wa] = wd;
        @(posedge clk); #1;
        e1 = q1.pop_front();
        e2 = q2.pop_front();
        check({tag, "_rd1"}, 64'(rd1), 64'(e1));
        check({tag, "_rd2"}, 64'(rd2), 64'(e2));
`ifdef REGFILE_DEBUG_PORT_EN
        check({tag, "_dbg"}, 64'(dbg_d), 64'(qd.pop_front()));
`endif
        last1 = e1;
        last2 = e2;
        we = 1'b0;
        re = 1'b0;
    endtask

    // Count edges from the reset edge until busy falls, bounded.
    task automatic wait_clear(input string tag);
        int cnt = 0;
        we = 1'b1; wa = 5'd5; wd = 32'hDEAD; re = 1'b1;
        while (busy && cnt < 100) begin
            ra1 = AW'(cnt);
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, "_busy_len"}, 64'(cnt), 64'd32);
        check({tag, "_clr_rd1"}, 64'(rd1), 64'd0);
        check({tag, "_clr_rd2"}, 64'(rd2), 64'd0);
        we = 1'b0; re = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        last1 = '0;
        last2 = '0;
    endtask

    initial begin
        // Reset state
        @(posedge clk); #1;
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_rd1", 64'(rd1), 64'd0);
        check("rst_rd2", 64'(rd2), 64'd0);
        reset = 1'b0;
        wait_clear("clr1");

        // All entries cleared. Entry 5 was written during busy and the write was dropped.
        for (int i = 0; i < 32; i++) rw("clr_read", 1, i, 31 - i, 0, 0, '0);

        // Basic write then read
        rw("wr3", 0, 0, 0, 1, 3, 32'h12345678);
        rw("rd3", 1, 3, 4, 0, 0, '0);

        // Same-edge bypass on both ports; debug port sees the old value
        rw("byp7", 1, 7, 7, 1, 7, 32'hCAFEF00D);
        rw("rd7", 1, 7, 3, 0, 0, '0);

        // Zero register
        rw("wr0", 0, 0, 0, 1, 0, 32'hFFFFFFFF);
        rw("rd0", 1, 0, 3, 0, 0, '0);
        rw("byp0", 1, 0, 0, 1, 0, 32'h55AA55AA);

        // Read hold
        rw("hold_pre", 1, 3, 7, 0, 0, '0);
        rw("hold_w9", 0, 9, 9, 1, 9, 32'h99990009);
        rw("hold_idle", 0, 9, 0, 0, 0, '0);
        rw("rd9", 1, 9, 3, 0, 0, '0);

        // Mixed random traffic
        for (int i = 0; i < 40; i++)
            rw("rand", int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 31)), DW'($urandom));

        // Reset mid-clear: entry 12 holds data before the reset
        rw("wr12", 0, 0, 0, 1, 12, 32'h0000ABCD);
        rw("rd12_pre", 1, 12, 9, 0, 0, '0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst2_rd1", 64'(rd1), 64'd0);
        check("rst2_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("mid_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        wait_clear("clr2");
        rw("rd12_post", 1, 12, 9, 0, 0, '0);
        rw("rd3_post", 1, 3, 7, 0, 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
